// File: rtl/pwm_gen.sv
// pwm_gen: complementary PWM gate-drive pair with programmable period, duty and
// dead time. A new configuration is taken into a shadow register through a
// valid/ready port and moved to the active set only on a period boundary (or
// while the generator is disabled), so a running waveform never glitches.
//
// Handshake: a configuration transfers on every rising clk edge where
// cfg_valid & cfg_ready are both 1. cfg_ready depends only on internal state
// (the shadow register being empty), never on cfg_valid. The offering side
// holds cfg_valid and the cfg_* fields stable until the transfer happens.
module pwm_gen #(
    parameter int CNT_W      = 16,
    parameter int DEAD_W     = 8,
    parameter int DEF_PERIOD = 100,
    parameter int DEF_DUTY   = 50,
    parameter int DEF_DEAD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_duty,
    input  logic [DEAD_W-1:0] cfg_dead,
    output logic              ctrl,
    output logic              ctrl_n,
    output logic              period_start,
    output logic              cfg_pending
);

    localparam logic [CNT_W-1:0]  PERIOD_RST = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0]  DUTY_RST   = CNT_W'(DEF_DUTY);
    localparam logic [DEAD_W-1:0] DEAD_RST   = DEAD_W'(DEF_DEAD);
    localparam logic [CNT_W-1:0]  PERIOD_MIN = CNT_W'(2);
    localparam logic [DEAD_W-1:0] RUN_MAX    = '1;

    // shadow (offered) and active (in use) configuration
    logic [CNT_W-1:0]  sh_period, sh_duty;
    logic [DEAD_W-1:0] sh_dead;
    logic              pending;
    logic [CNT_W-1:0]  period_act, duty_act;
    logic [DEAD_W-1:0] dead_act;

    logic [CNT_W-1:0]  cnt;
    logic [DEAD_W-1:0] hi_run, lo_run;

    logic accept;
    logic wrap;
    logic apply;
    logic raw;

    assign cfg_ready   = !pending;
    assign cfg_pending = pending;

    // accept and apply are mutually exclusive: one needs pending=0, the other pending=1,
    // so a config accepted on a wrap cycle is only applied at the following wrap
    assign accept = cfg_valid && !pending;
    assign wrap   = en && (cnt == period_act - CNT_W'(1));
    assign apply  = pending && (wrap || !en);
    assign raw    = (cnt < duty_act);

    // shadow register and pending flag; periods below 2 are clamped to 2
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_period <= PERIOD_RST;
            sh_duty   <= DUTY_RST;
            sh_dead   <= DEAD_RST;
            pending   <= 1'b0;
        end else if (accept) begin
            sh_period <= (cfg_period < PERIOD_MIN) ? PERIOD_MIN : cfg_period;
            sh_duty   <= cfg_duty;
            sh_dead   <= cfg_dead;
            pending   <= 1'b1;
        end else if (apply) begin
            pending   <= 1'b0;
        end
    end

    // active configuration, replaced only on a wrap or while disabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_act <= PERIOD_RST;
            duty_act   <= DUTY_RST;
            dead_act   <= DEAD_RST;
        end else if (apply) begin
            period_act <= sh_period;
            duty_act   <= sh_duty;
            dead_act   <= sh_dead;
        end
    end

    // period counter, parked at 0 while disabled so each enable starts a fresh period
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!en || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // run counters: number of earlier consecutive cycles with the same raw level,
    // so the first cycle of a run sees 0; saturating, cleared on a level change
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_run <= '0;
            lo_run <= '0;
        end else if (!en) begin
            hi_run <= '0;
            lo_run <= '0;
        end else if (raw) begin
            lo_run <= '0;
            if (hi_run != RUN_MAX) hi_run <= hi_run + DEAD_W'(1);
        end else begin
            hi_run <= '0;
            if (lo_run != RUN_MAX) lo_run <= lo_run + DEAD_W'(1);
        end
    end

    // registered gate drives and period marker; a level must persist dead_act cycles
    // before its output turns on, which keeps ctrl and ctrl_n from overlapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl         <= 1'b0;
            ctrl_n       <= 1'b0;
            period_start <= 1'b0;
        end else begin
            ctrl         <= en && raw && (hi_run >= dead_act);
            ctrl_n       <= en && !raw && (lo_run >= dead_act);
            period_start <= en && (cnt == '0);
        end
    end

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: directed scenarios plus randomized configuration/enable/reset traffic,
// every cycle compared against a behavioural model of the PWM generator.
module tb_pwm_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_period;
    logic [15:0] cfg_duty;
    logic [7:0]  cfg_dead;
    logic        ctrl;
    logic        ctrl_n;
    logic        period_start;
    logic        cfg_pending;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // scoreboard: expected {ctrl, ctrl_n, period_start, cfg_ready, cfg_pending}
    logic [4:0] exp_q[$];

    // reference model state
    int m_cnt, m_per, m_duty, m_dead;
    int s_per, s_duty, s_dead;
    bit m_pend;
    bit hist[$];   // raw levels seen since the generator was last enabled

    pwm_gen dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_period   (cfg_period),
        .cfg_duty     (cfg_duty),
        .cfg_dead     (cfg_dead),
        .ctrl         (ctrl),
        .ctrl_n       (ctrl_n),
        .period_start (period_start),
        .cfg_pending  (cfg_pending)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_per  = 100;
        m_duty = 50;
        m_dead = 0;
        s_per  = 100;
        s_duty = 50;
        s_dead = 0;
        m_pend = 0;
        hist.delete();
    endtask

    // one cycle of the model: outputs for the coming edge, then the state after it
    task automatic model_eval(output logic [4:0] e);
        bit raw;
        int run;
        bit e_c, e_n, e_ps;
        bit wrap;
        raw  = (m_cnt < m_duty);
        e_c  = 0;
        e_n  = 0;
        e_ps = en && (m_cnt == 0);
        if (en) begin
            hist.push_back(raw);
            if (hist.size() > 300) void'(hist.pop_front());
            run = 0;
            for (int i = hist.size() - 1; i >= 0; i--) begin
                if (hist[i] != raw) break;
                run++;
            end
            // the current level must have lasted more than dead cycles
            e_c = raw && (run > m_dead);
            e_n = !raw && (run > m_dead);
        end else begin
            hist.delete();
        end
        wrap = en && (m_cnt == m_per - 1);
        if (m_pend && (wrap || !en)) begin
            m_per  = s_per;
            m_duty = s_duty;
            m_dead = s_dead;
            m_pend = 0;
        end else if (cfg_valid && !m_pend) begin
            s_per  = (cfg_period < 2) ? 2 : int'(cfg_period);
            s_duty = int'(cfg_duty);
            s_dead = int'(cfg_dead);
            m_pend = 1;
        end
        m_cnt = (!en || wrap) ? 0 : m_cnt + 1;
        e = {e_c, e_n, e_ps, !m_pend, m_pend};
    endtask

    // driver: advance one clock, drop cfg_valid after a transfer, compare outputs
    task automatic step();
        logic [4:0] e;
        logic hs;
        hs = cfg_valid && cfg_ready;
        model_eval(e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (hs) cfg_valid = 1'b0;
        e = exp_q.pop_front();
        check("ctrl", ctrl, e[4]);
        check("ctrl_n", ctrl_n, e[3]);
        check("period_start", period_start, e[2]);
        check("cfg_ready", cfg_ready, e[1]);
        check("cfg_pending", cfg_pending, e[0]);
        check("excl", ctrl & ctrl_n, 0);
    endtask

    task automatic run_n(input int n, inout int hi, inout int lo);
        for (int i = 0; i < n; i++) begin
            step();
            hi += ctrl;
            lo += ctrl_n;
        end
    endtask

    task automatic run_to_start();
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!period_start && k < 400);
        check("ps_found", period_start, 1);
    endtask

    task automatic send_cfg(input int p, input int d, input int dd);
        int k;
        cfg_valid  = 1'b1;
        cfg_period = 16'(p);
        cfg_duty   = 16'(d);
        cfg_dead   = 8'(dd);
        k = 0;
        while (cfg_valid && k < 1000) begin
            step();
            k++;
        end
        check("cfg_accept", cfg_valid, 0);
        cfg_valid = 1'b0;
    endtask

    // asynchronous reset between edges, outputs checked before any clock edge
    task automatic do_reset();
        #2;
        rst = 1'b0;
        cfg_valid = 1'b0;
        model_reset();
        #1;
        check("rst_ctrl", ctrl, 0);
        check("rst_ctrl_n", ctrl_n, 0);
        check("rst_ps", period_start, 0);
        check("rst_ready", cfg_ready, 1);
        check("rst_pending", cfg_pending, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic rand_cfg();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) begin
            cfg_period = 16'($urandom_range(0, 1));
            cfg_duty   = 16'($urandom_range(0, 2));
            cfg_dead   = 8'($urandom_range(0, 1));
        end else if (r == 1) begin
            cfg_period = 16'($urandom_range(200, 300));
            cfg_duty   = 16'($urandom_range(0, 320));
            cfg_dead   = 8'($urandom_range(100, 255));
        end else begin
            cfg_period = 16'($urandom_range(2, 40));
            cfg_duty   = 16'($urandom_range(0, 45));
            cfg_dead   = 8'($urandom_range(0, 8));
        end
    endtask

    initial begin
        int hi, lo;
        rst        = 1'b0;
        en         = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = '0;
        cfg_duty   = '0;
        cfg_dead   = '0;
        model_reset();
        #1;
        check("init_ctrl", ctrl, 0);
        check("init_ctrl_n", ctrl_n, 0);
        check("init_ps", period_start, 0);
        check("init_ready", cfg_ready, 1);
        check("init_pending", cfg_pending, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // defaults: 50/50 over 100 cycles, first ctrl together with period_start
        en = 1'b1;
        step();
        check("t1_first_ctrl", ctrl, 1);
        check("t1_first_ps", period_start, 1);
        hi = int'(ctrl);
        lo = int'(ctrl_n);
        run_n(99, hi, lo);
        check("t1_hi", hi, 50);
        check("t1_lo", lo, 50);

        // mid-period config takes effect at the next period only
        hi = 0;
        lo = 0;
        run_n(20, hi, lo);
        send_cfg(100, 30, 5);
        check("t2_pending", cfg_pending, 1);
        run_to_start();
        hi = int'(ctrl);
        lo = int'(ctrl_n);
        run_n(99, hi, lo);
        check("t2_hi", hi, 25);
        check("t2_lo", lo, 65);

        // two configs back-to-back
        hi = 0;
        lo = 0;
        run_n(10, hi, lo);
        send_cfg(60, 20, 0);
        check("t3_ready_low", cfg_ready, 0);
        cfg_valid  = 1'b1;
        cfg_period = 16'd40;
        cfg_duty   = 16'd10;
        cfg_dead   = 8'd2;
        run_to_start();
        hi = int'(ctrl);
        lo = int'(ctrl_n);
        run_n(59, hi, lo);
        check("t3a_hi", hi, 20);
        check("t3a_lo", lo, 40);
        run_to_start();
        hi = int'(ctrl);
        lo = int'(ctrl_n);
        run_n(39, hi, lo);
        check("t3b_hi", hi, 8);
        check("t3b_lo", lo, 28);

        // duty 0 and duty above period
        send_cfg(100, 0, 0);
        run_to_start();
        hi = 0;
        lo = 0;
        run_n(150, hi, lo);
        check("t4a_hi", hi, 0);
        check("t4a_lo", lo, 150);
        send_cfg(100, 120, 0);
        run_to_start();
        hi = 0;
        lo = 0;
        run_n(150, hi, lo);
        check("t4b_hi", hi, 150);
        check("t4b_lo", lo, 0);

        // period clamped to 2, outputs alternate
        send_cfg(0, 1, 0);
        run_to_start();
        hi = int'(ctrl);
        lo = int'(ctrl_n);
        run_n(7, hi, lo);
        check("t5a_hi", hi, 4);
        check("t5a_lo", lo, 4);
        send_cfg(1, 1, 0);
        run_to_start();
        hi = int'(ctrl);
        lo = int'(ctrl_n);
        run_n(5, hi, lo);
        check("t5b_hi", hi, 3);
        check("t5b_lo", lo, 3);

        // enable dropped with a config offered: applied while disabled
        send_cfg(100, 50, 0);
        run_to_start();
        hi = 0;
        lo = 0;
        run_n(30, hi, lo);
        en         = 1'b0;
        cfg_valid  = 1'b1;
        cfg_period = 16'd50;
        cfg_duty   = 16'd10;
        cfg_dead   = 8'd0;
        step();
        check("t6_off_ctrl", ctrl, 0);
        check("t6_off_ctrl_n", ctrl_n, 0);
        check("t6_off_pending", cfg_pending, 1);
        step();
        check("t6_applied", cfg_pending, 0);
        en = 1'b1;
        step();
        check("t6_restart_ps", period_start, 1);
        hi = int'(ctrl);
        lo = int'(ctrl_n);
        run_n(49, hi, lo);
        check("t6_hi", hi, 10);
        check("t6_lo", lo, 40);

        // asynchronous reset mid-period with a config being offered
        hi = 0;
        lo = 0;
        run_n(17, hi, lo);
        cfg_valid  = 1'b1;
        cfg_period = 16'd30;
        cfg_duty   = 16'd3;
        do_reset();
        step();
        check("t6_rst_ps", period_start, 1);
        hi = int'(ctrl);
        lo = int'(ctrl_n);
        run_n(99, hi, lo);
        check("t6_rst_hi", hi, 50);
        check("t6_rst_lo", lo, 50);

        // randomized traffic
        for (int c = 0; c < 12000; c++) begin
            if (!cfg_valid && $urandom_range(0, 99) < 4) begin
                cfg_valid = 1'b1;
                rand_cfg();
            end
            if ($urandom_range(0, 999) < 4) en = !en;
            if ($urandom_range(0, 3999) == 0) do_reset();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
